ahb_split_ctrl: RTL and testbench
=================================

AHB_SPLIT_CTRL -- requirements
Module: ahb_split_ctrl

Interface
REQ-001 SHALL have parameter SPLIT_EN, default 1: 1 = busy-resource transfers get SPLIT, 0 = wait states instead.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 HCLK  input  1  bus clock, all state updates on rising edge.
REQ-004 HRESETn  input  1  asynchronous active-low reset.
REQ-005 HSEL  input  1  slave select.
REQ-006 HTRANS  input  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-007 HREADY  input  1  bus-level ready.
REQ-008 HMASTER  input  4  current address-phase master number.
REQ-009 HMASTLOCK  input  1  current transfer is locked.
REQ-010 res_ready  input  1  shared resource can accept a transfer.
REQ-011 HREADYOUT  output  1  slave ready.
REQ-012 HRESP  output  2  response (OKAY=00, SPLIT=11).
REQ-013 HSPLITx  output  16  one-hot, one-cycle release of a split master.
REQ-014 accept  output  1  one-cycle pulse: transfer handed to resource.
REQ-015 split_pending  output  16  masters currently held in SPLIT.

Function
REQ-016 Valid transfer SHALL mean HSEL & HREADY & HTRANS[1] sampled in IDLE state.
REQ-017 FSM states SHALL be IDLE, SPLIT1, SPLIT2, LWAIT.
REQ-018 IDLE, valid transfer, res_ready=1: next cycle accept=1, HREADYOUT=1, HRESP=OKAY, stay IDLE.
REQ-019 IDLE, valid transfer, res_ready=0, HMASTLOCK=0, SPLIT_EN=1: register HMASTER, go SPLIT1.
REQ-020 SPLIT1: HREADYOUT=0, HRESP=SPLIT; next state SPLIT2 unconditionally.
REQ-021 SPLIT2: HREADYOUT=1, HRESP=SPLIT; split_pending[registered master] set on the SPLIT1->SPLIT2 edge; next state IDLE.
REQ-022 IDLE, valid transfer, res_ready=0 and (HMASTLOCK=1 or SPLIT_EN=0): go LWAIT with HREADYOUT=0, HRESP=OKAY.
REQ-023 LWAIT: hold HREADYOUT=0 while res_ready=0; on res_ready=1 pulse accept, HREADYOUT=1, return IDLE.
REQ-024 Non-valid transfer (HSEL=0, HTRANS IDLE/BUSY, or HREADY=0) in IDLE SHALL give HREADYOUT=1, HRESP=OKAY, no state change.
REQ-025 Release: when res_ready=1 and split_pending!=0, exactly one HSPLITx bit SHALL pulse per cycle, chosen round-robin starting at index rr_ptr.
REQ-026 On release of master m: clear split_pending[m] same edge, rr_ptr <= (m+1) mod 16 (wraps 15->0).
REQ-027 Release SHALL run in any FSM state; a set and a release of the same bit on one edge SHALL leave the bit set.
REQ-028 res_ready=0 SHALL suppress all release; HSPLITx=0.
REQ-029 A master with split_pending set issuing a transfer SHALL be treated normally (re-split if still busy).
REQ-030 All outputs SHALL be registered; accept and HSPLITx are single-cycle pulses.

Reset
REQ-031 HRESETn=0 SHALL force, asynchronously: state=IDLE, HREADYOUT=1, HRESP=OKAY, HSPLITx=0, accept=0, split_pending=0, rr_ptr=0.
REQ-032 Reset mid-SPLIT1/LWAIT SHALL abandon the transfer; no pending bit set, no accept.

Structure
REQ-033 Shared package ahb_pkg SHALL hold htrans_t, hresp_t enums, split_state_t, and NUM_MASTERS=16.
REQ-034 One sub-module ahb_rr_pick16 SHALL be used: combinational round-robin one-hot picker (request vector, start pointer -> grant).

Verification
REQ-035 Master 3 NONSEQ, res_ready=1 -> accept pulse next cycle, HRESP=OKAY, HREADYOUT=1.
REQ-036 Master 5 NONSEQ, res_ready=0 -> HREADYOUT 0 then 1 with HRESP=SPLIT both cycles; split_pending=16'h0020.
REQ-037 Masters 2, 9, 14 split, rr_ptr=10, res_ready rises -> HSPLITx 16'h4000, 16'h0004, 16'h0200 on three consecutive cycles, pending 0.
REQ-038 Locked master 1, res_ready=0 for 4 cycles -> 4 wait cycles HRESP=OKAY, accept on res_ready=1, no pending bit.
REQ-039 HRESETn asserted in SPLIT1 -> all outputs at reset values immediately, split_pending=0.
REQ-040 SPLIT_EN=0, master 7, res_ready=0 for 2 cycles -> LWAIT 2 cycles, then accept, no SPLIT response.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB types and constants for the split-capable slave controller.
package ahb_pkg;

    localparam int unsigned NUM_MASTERS = 16;
    localparam int unsigned MIDX_W      = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPLIT1,
        ST_SPLIT2,
        ST_LWAIT
    } split_state_t;

    // Index of the set bit in a one-hot master vector (0 when empty).
    function automatic logic [MIDX_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
        logic [MIDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (oh[i]) idx = i[MIDX_W-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_rr_pick16.sv
// Combinational round-robin picker: grants the first set request at or after ptr.
module ahb_rr_pick16
    import ahb_pkg::*;
(
    input  logic [15:0] req,
    input  logic [3:0]  ptr,
    output logic [15:0] gnt
);

    // Scan upward from ptr with 4-bit wrap; first hit wins.
    always_comb begin
        logic       found;
        logic [3:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            idx = ptr + i[3:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_split_ctrl.sv
// AHB slave front-end for a shared resource: accepts, splits or wait-states
// transfers and releases split masters round-robin once the resource frees up.
module ahb_split_ctrl
    import ahb_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic [3:0]  HMASTER,
    input  logic        HMASTLOCK,
    input  logic        res_ready,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [15:0] HSPLITx,
    output logic        accept,
    output logic [15:0] split_pending
);

    split_state_t state_q, state_d;
    logic [3:0]   master_q, master_d;
    logic         hready_q, hready_d;
    hresp_t       hresp_q, hresp_d;
    logic         accept_q, accept_d;
    logic [15:0]  hsplit_q, hsplit_d;
    logic [15:0]  pend_q, pend_d;
    logic [3:0]   rr_q, rr_d;

    logic         valid;
    logic [15:0]  set_pend;
    logic [15:0]  grant;

    assign valid = HSEL && HREADY &&
                   ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    ahb_rr_pick16 u_pick (
        .req (pend_q),
        .ptr (rr_q),
        .gnt (grant)
    );

    // Transfer FSM: next state plus the registered response for the next cycle.
    always_comb begin
        state_d  = state_q;
        master_d = master_q;
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        accept_d = 1'b0;
        set_pend = '0;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    if (res_ready) begin
                        accept_d = 1'b1;
                    end else if (!HMASTLOCK && SPLIT_EN) begin
                        master_d = HMASTER;
                        state_d  = ST_SPLIT1;
                        hready_d = 1'b0;
                        hresp_d  = HRESP_SPLIT;
                    end else begin
                        state_d  = ST_LWAIT;
                        hready_d = 1'b0;
                    end
                end
            end
            ST_SPLIT1: begin
                state_d            = ST_SPLIT2;
                hresp_d            = HRESP_SPLIT;
                set_pend[master_q] = 1'b1;
            end
            ST_SPLIT2: begin
                state_d = ST_IDLE;
            end
            ST_LWAIT: begin
                if (res_ready) begin
                    accept_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    hready_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Release one split master per cycle; clear first, then set, so a same-edge set wins.
    always_comb begin
        hsplit_d = '0;
        rr_d     = rr_q;
        if (res_ready && (pend_q != '0)) begin
            hsplit_d = grant;
            rr_d     = onehot_to_idx(grant) + 4'd1;
        end
        pend_d = (pend_q & ~hsplit_d) | set_pend;
    end

    // State and output registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            master_q <= '0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            accept_q <= 1'b0;
            hsplit_q <= '0;
            pend_q   <= '0;
            rr_q     <= '0;
        end else begin
            state_q  <= state_d;
            master_q <= master_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            accept_q <= accept_d;
            hsplit_q <= hsplit_d;
            pend_q   <= pend_d;
            rr_q     <= rr_d;
        end
    end

    assign HREADYOUT     = hready_q;
    assign HRESP         = hresp_q;
    assign HSPLITx       = hsplit_q;
    assign accept        = accept_q;
    assign split_pending = pend_q;

endmodule

// File: tb/tb_ahb_split_ctrl.sv
// Bench for ahb_split_ctrl: two instances (split enabled / disabled) against a
// transaction-level model, plus hand-computed directed expectations.
module tb_ahb_split_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HREADY = 1'b1;
    logic [3:0]  HMASTER = 4'd0;
    logic        HMASTLOCK = 1'b0;
    logic        res_ready = 1'b0;

    logic        ro0, ro1, acc0, acc1;
    logic [1:0]  rsp0, rsp1;
    logic [15:0] hs0, hs1, pd0, pd1;

    int checks = 0;
    int errors = 0;
    logic seen_split1 = 1'b0;

    always #5 HCLK = ~HCLK;

    ahb_split_ctrl #(.SPLIT_EN(1'b1)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(HREADY),
        .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK), .res_ready(res_ready),
        .HREADYOUT(ro0), .HRESP(rsp0), .HSPLITx(hs0), .accept(acc0), .split_pending(pd0)
    );

    ahb_split_ctrl #(.SPLIT_EN(1'b0)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(HREADY),
        .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK), .res_ready(res_ready),
        .HREADYOUT(ro1), .HRESP(rsp1), .HSPLITx(hs1), .accept(acc1), .split_pending(pd1)
    );

    // ---------------- behavioural model ----------------
    // Each accepted address phase schedules a list of response beats; the
    // model just plays them back, and a locked/no-split wait is open-ended.
    typedef struct packed {
        logic       rdy;
        logic [1:0] rsp;
        logic       acc;
        logic       setp;
    } beat_t;

    beat_t       qb [2][4];
    int          qn [2];
    logic        waiting [2];
    logic [15:0] pend [2];
    int          rr [2];
    int          mst [2];
    logic        ex_rdy [2];
    logic [1:0]  ex_rsp [2];
    logic        ex_acc [2];
    logic [15:0] ex_hs [2];

    always @(posedge HCLK or negedge HRESETn) begin
        beat_t b;
        logic  v;
        logic  done;
        int    idx;
        for (int k = 0; k < 2; k++) begin
            if (!HRESETn) begin
                qn[k] = 0; waiting[k] = 1'b0; pend[k] = 16'h0; rr[k] = 0; mst[k] = 0;
                ex_rdy[k] = 1'b1; ex_rsp[k] = 2'b00; ex_acc[k] = 1'b0; ex_hs[k] = 16'h0;
            end else begin
                ex_hs[k] = 16'h0;
                if (res_ready && pend[k] != 16'h0) begin
                    done = 1'b0;
                    for (int i = 0; i < 16; i++) begin
                        idx = (rr[k] + i) % 16;
                        if (!done && pend[k][idx]) begin
                            ex_hs[k] = 16'h1 << idx;
                            pend[k][idx] = 1'b0;
                            rr[k] = (idx + 1) % 16;
                            done = 1'b1;
                        end
                    end
                end
                v = HSEL && HREADY && HTRANS[1];
                b = '{rdy: 1'b1, rsp: 2'b00, acc: 1'b0, setp: 1'b0};
                if (waiting[k]) begin
                    if (res_ready) begin
                        b.acc = 1'b1;
                        waiting[k] = 1'b0;
                    end else begin
                        b.rdy = 1'b0;
                    end
                end else if (qn[k] > 0) begin
                    b = qb[k][0];
                    for (int j = 0; j < 3; j++) qb[k][j] = qb[k][j+1];
                    qn[k]--;
                end else if (v) begin
                    if (res_ready) begin
                        b.acc = 1'b1;
                    end else if (!HMASTLOCK && k == 0) begin
                        b = '{rdy: 1'b0, rsp: 2'b11, acc: 1'b0, setp: 1'b0};
                        qb[k][0] = '{rdy: 1'b1, rsp: 2'b11, acc: 1'b0, setp: 1'b1};
                        qb[k][1] = '{rdy: 1'b1, rsp: 2'b00, acc: 1'b0, setp: 1'b0};
                        qn[k] = 2;
                        mst[k] = int'(HMASTER);
                    end else begin
                        b.rdy = 1'b0;
                        waiting[k] = 1'b1;
                    end
                end
                if (b.setp) pend[k][mst[k]] = 1'b1;
                ex_rdy[k] = b.rdy; ex_rsp[k] = b.rsp; ex_acc[k] = b.acc;
            end
        end
    end

    // Cycle-by-cycle compare of both instances against the model.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            checks++;
            if ({ro0, rsp0, acc0, hs0, pd0} !== {ex_rdy[0], ex_rsp[0], ex_acc[0], ex_hs[0], pend[0]}) begin
                errors++;
                $display("FAIL cyc_split_en t=%0t actual rdy=%b rsp=%b acc=%b hs=%h pd=%h required rdy=%b rsp=%b acc=%b hs=%h pd=%h",
                         $time, ro0, rsp0, acc0, hs0, pd0, ex_rdy[0], ex_rsp[0], ex_acc[0], ex_hs[0], pend[0]);
            end
            checks++;
            if ({ro1, rsp1, acc1, hs1, pd1} !== {ex_rdy[1], ex_rsp[1], ex_acc[1], ex_hs[1], pend[1]}) begin
                errors++;
                $display("FAIL cyc_no_split t=%0t actual rdy=%b rsp=%b acc=%b hs=%h pd=%h required rdy=%b rsp=%b acc=%b hs=%h pd=%h",
                         $time, ro1, rsp1, acc1, hs1, pd1, ex_rdy[1], ex_rsp[1], ex_acc[1], ex_hs[1], pend[1]);
            end
            if (rsp1 == 2'b11) seen_split1 = 1'b1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic [3:0] m, input logic lock);
        HSEL = sel; HTRANS = sel ? 2'b10 : 2'b00; HMASTER = m; HMASTLOCK = lock;
    endtask

    task automatic do_split(input logic [3:0] m);
        drive(1'b1, m, 1'b0);
        @(negedge HCLK);
        drive(1'b0, 4'd0, 1'b0);
        repeat (2) @(negedge HCLK);
    endtask

    task automatic idle_cycles(input int n);
        drive(1'b0, 4'd0, 1'b0);
        res_ready = 1'b1;
        repeat (n) @(negedge HCLK);
    endtask

    initial begin
        int w;
        logic [15:0] s0, s1, s2;

        // reset state
        #12;
        chk("rst_hreadyout", ro0, 1);
        chk("rst_hresp", rsp0, 0);
        chk("rst_pending", pd0, 0);
        chk("rst_hsplit", hs0, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        idle_cycles(2);

        // master 3, resource ready: accept next cycle
        drive(1'b1, 4'd3, 1'b0);
        @(negedge HCLK);
        chk("m3_accept", acc0, 1);
        chk("m3_ready", ro0, 1);
        chk("m3_resp", rsp0, 0);
        drive(1'b0, 4'd0, 1'b0);
        @(negedge HCLK);
        chk("m3_accept_pulse", acc0, 0);

        // master 5, resource busy: two-cycle SPLIT, pending bit 5
        res_ready = 1'b0;
        drive(1'b1, 4'd5, 1'b0);
        @(negedge HCLK);
        chk("m5_split1_ready", ro0, 0);
        chk("m5_split1_resp", rsp0, 2'b11);
        drive(1'b0, 4'd0, 1'b0);
        @(negedge HCLK);
        chk("m5_split2_ready", ro0, 1);
        chk("m5_split2_resp", rsp0, 2'b11);
        chk("m5_pending", pd0, 16'h0020);
        @(negedge HCLK);
        chk("m5_after_resp", rsp0, 0);
        res_ready = 1'b1;
        @(negedge HCLK);
        chk("m5_release", hs0, 16'h0020);
        chk("m5_cleared", pd0, 0);
        idle_cycles(2);

        // reset during SPLIT1
        res_ready = 1'b0;
        drive(1'b1, 4'd4, 1'b0);
        @(negedge HCLK);
        drive(1'b0, 4'd0, 1'b0);
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_mid_ready", ro0, 1);
        chk("rst_mid_resp", rsp0, 0);
        chk("rst_mid_pending", pd0, 0);
        chk("rst_mid_accept", acc0, 0);
        #1 HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        chk("rst_mid_no_pending", pd0, 0);
        idle_cycles(2);

        // round-robin release from rr_ptr=10
        res_ready = 1'b0;
        do_split(4'd9);
        res_ready = 1'b1;
        @(negedge HCLK);
        chk("rr_setup_release9", hs0, 16'h0200);
        res_ready = 1'b0;
        do_split(4'd2);
        do_split(4'd9);
        do_split(4'd14);
        chk("rr_pending3", pd0, 16'h4204);
        res_ready = 1'b1;
        @(negedge HCLK); s0 = hs0;
        @(negedge HCLK); s1 = hs0;
        @(negedge HCLK); s2 = hs0;
        chk("rr_first", s0, 16'h4000);
        chk("rr_second", s1, 16'h0004);
        chk("rr_third", s2, 16'h0200);
        chk("rr_empty", pd0, 0);
        idle_cycles(2);

        // locked master 1: four wait states then accept
        res_ready = 1'b0;
        w = 0;
        drive(1'b1, 4'd1, 1'b1);
        @(negedge HCLK);
        if (ro0 == 1'b0) w++;
        drive(1'b0, 4'd0, 1'b0);
        HREADY = 1'b0;
        repeat (3) begin
            @(negedge HCLK);
            if (ro0 == 1'b0) w++;
            chk("lock_wait_resp", rsp0, 0);
        end
        res_ready = 1'b1;
        HREADY = 1'b1;
        @(negedge HCLK);
        chk("lock_waits", w, 4);
        chk("lock_accept", acc0, 1);
        chk("lock_ready", ro0, 1);
        chk("lock_no_pending", pd0, 0);
        idle_cycles(2);

        // split disabled instance, master 7: two wait cycles then accept
        res_ready = 1'b0;
        w = 0;
        drive(1'b1, 4'd7, 1'b0);
        @(negedge HCLK);
        if (ro1 == 1'b0) w++;
        chk("nosplit_resp", rsp1, 0);
        drive(1'b0, 4'd0, 1'b0);
        @(negedge HCLK);
        if (ro1 == 1'b0) w++;
        res_ready = 1'b1;
        @(negedge HCLK);
        chk("nosplit_waits", w, 2);
        chk("nosplit_accept", acc1, 1);
        chk("nosplit_pending", pd1, 0);
        idle_cycles(3);

        // mixed traffic; the per-cycle compare carries the checking
        for (int i = 0; i < 400; i++) begin
            HSEL      = ($urandom_range(0, 3) != 0);
            HTRANS    = 2'($urandom_range(0, 3));
            HREADY    = ($urandom_range(0, 7) != 0);
            HMASTER   = 4'($urandom_range(0, 15));
            HMASTLOCK = ($urandom_range(0, 7) == 0);
            res_ready = ($urandom_range(0, 2) == 0);
            @(negedge HCLK);
        end
        idle_cycles(20);

        chk("nosplit_never_split", seen_split1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
